// File: rtl/xbar_alloc_if.sv
// ============================================================================
// xbar_alloc_if : request/release/configuration bundle of the crossbar allocator
// Rev 1.0
// ============================================================================
`default_nettype none

interface xbar_alloc_if #(
  parameter int NN = 2,
  parameter int MN = 3
);
  logic [NN-1:0][MN-1:0] req;
  logic [NN-1:0]         rel;
  logic [MN-1:0][NN-1:0] cfg;
  logic [NN-1:0]         gnt;
  logic                  err;

  modport master (output req, rel, input cfg, gnt, err);
  modport slave  (input req, rel, output cfg, gnt, err);
endinterface

`default_nettype wire

// File: rtl/xbar_alloc.sv
// ============================================================================
// xbar_alloc : wormhole allocator, round-robin per output, held until release
// Rev 1.0
// ============================================================================
`default_nettype none

module xbar_alloc #(
  parameter int NN = 2,
  parameter int MN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  xbar_alloc_if.slave bus
);

  localparam int            IW      = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_BUSY = 1'b1;
  localparam logic [IW-1:0] C_LAST  = IW'(NN - 1);
  localparam logic [IW:0]   C_NN    = (IW + 1)'(NN);

  logic [0:0]            r_state [MN];
  logic [IW-1:0]         r_owner [MN];
  logic [IW-1:0]         r_ptr   [MN];
  logic [NN-1:0]         r_cfg   [MN];
  logic [NN-1:0][MN-1:0] r_req_prev;
  logic                  r_err;

  logic [NN-1:0]         w_onehot;
  logic [NN-1:0]         w_multi;
  logic [NN-1:0]         w_changed;
  logic [NN-1:0]         w_gnt;
  logic [MN-1:0][NN-1:0] w_elig;
  logic [MN-1:0]         w_found;
  logic [IW-1:0]         w_win     [MN];
  logic [IW-1:0]         w_ptr_nxt [MN];
  logic                  w_err_set;

  always_comb begin
    w_gnt = '0;
    for (int o = 0; o < MN; o++) begin
      w_gnt = w_gnt | r_cfg[o];
    end
    for (int i = 0; i < NN; i++) begin
      w_onehot[i]  = ($countones(bus.req[i]) == 1);
      w_multi[i]   = ($countones(bus.req[i]) > 1);
      w_changed[i] = (bus.req[i] != r_req_prev[i]);
    end
    // A changed request in the eof cycle is the sanctioned next-packet handoff.
    w_err_set = (|w_multi) | (|(w_gnt & ~bus.rel & w_changed));
  end

  // Granted inputs are excluded, so no input can win two outputs at once.
  always_comb begin : p_arb
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    sum = '0;
    idx = '0;
    for (int o = 0; o < MN; o++) begin
      for (int i = 0; i < NN; i++) begin
        w_elig[o][i] = bus.req[i][o] & w_onehot[i] & ~w_gnt[i];
      end
      w_found[o] = 1'b0;
      w_win[o]   = '0;
      for (int k = 0; k < NN; k++) begin
        sum = {1'b0, r_ptr[o]} + (IW + 1)'(k);
        if (sum >= C_NN) begin
          sum = sum - C_NN;
        end
        idx = sum[IW-1:0];
        if (!w_found[o] && w_elig[o][idx]) begin
          w_found[o] = 1'b1;
          w_win[o]   = idx;
        end
      end
      w_ptr_nxt[o] = (w_win[o] == C_LAST) ? '0 : w_win[o] + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < MN; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
        r_cfg[o]   <= '0;
      end
      r_req_prev <= '0;
      r_err      <= 1'b0;
    end else begin
      r_req_prev <= bus.req;
      r_err      <= r_err | w_err_set;
      for (int o = 0; o < MN; o++) begin
        case (r_state[o])
          ST_IDLE: begin
            if (w_found[o]) begin
              r_state[o] <= ST_BUSY;
              r_owner[o] <= w_win[o];
              r_ptr[o]   <= w_ptr_nxt[o];
              r_cfg[o]   <= NN'(1) << w_win[o];
            end
          end
          ST_BUSY: begin
            if (bus.rel[r_owner[o]]) begin
              r_state[o] <= ST_IDLE;
              r_cfg[o]   <= '0;
            end
          end
          default: begin
            r_state[o] <= ST_IDLE;
            r_cfg[o]   <= '0;
          end
        endcase
      end
    end
  end

  for (genvar o = 0; o < MN; o++) begin : g_cfg
    assign bus.cfg[o] = r_cfg[o];
  end

  assign bus.gnt = w_gnt;
  assign bus.err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_xbar_alloc.sv
// ============================================================================
// tb_xbar_alloc : directed vector bench for xbar_alloc (2x3 and 4x1 instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_xbar_alloc;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  xbar_alloc_if #(.NN(2), .MN(3)) ifa ();
  xbar_alloc_if #(.NN(4), .MN(1)) ifb ();

  xbar_alloc #(.NN(2), .MN(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  xbar_alloc #(.NN(4), .MN(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         pre_rst;
    logic [5:0] req;   // {req[1], req[0]}
    logic [1:0] rel;
    logic [5:0] cfg;   // {cfg[2], cfg[1], cfg[0]}
    logic [1:0] gnt;
    logic       err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 6'b100000, 2'b00, 6'b100000, 2'b10, 1'b0};
    vecs[1]  = '{1'b0, 6'b100000, 2'b10, 6'b000000, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 6'b000000, 2'b00, 6'b000000, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 6'b010001, 2'b00, 6'b001001, 2'b11, 1'b0};
    vecs[4]  = '{1'b0, 6'b010001, 2'b11, 6'b000000, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 6'b000000, 2'b00, 6'b000000, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 6'b000010, 2'b00, 6'b000100, 2'b01, 1'b0};
    vecs[7]  = '{1'b0, 6'b000100, 2'b00, 6'b000100, 2'b01, 1'b1};
    vecs[8]  = '{1'b0, 6'b000100, 2'b00, 6'b000100, 2'b01, 1'b1};
    vecs[9]  = '{1'b0, 6'b000100, 2'b00, 6'b000100, 2'b01, 1'b1};
    vecs[10] = '{1'b0, 6'b000100, 2'b01, 6'b000000, 2'b00, 1'b1};
    vecs[11] = '{1'b0, 6'b000100, 2'b00, 6'b010000, 2'b01, 1'b1};
    vecs[12] = '{1'b1, 6'b001011, 2'b00, 6'b000010, 2'b10, 1'b1};
    vecs[13] = '{1'b0, 6'b001011, 2'b00, 6'b000010, 2'b10, 1'b1};

    rst_n   = 1'b0;
    ifa.req = '0;
    ifa.rel = '0;
    ifb.req = '0;
    ifb.rel = '0;
    tick();
    tick();
    chk("reset cfg", 32'(ifa.cfg), 32'h0);
    chk("reset gnt", 32'(ifa.gnt), 32'h0);
    chk("reset err", 32'(ifa.err), 32'h0);
    chk("reset b gnt", 32'(ifb.gnt), 32'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 14; v++) begin
      if (vecs[v].pre_rst) begin
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
      end
      ifa.req = vecs[v].req;
      ifa.rel = vecs[v].rel;
      tick();
      chk($sformatf("v%0d cfg", v), 32'(ifa.cfg), 32'(vecs[v].cfg));
      chk($sformatf("v%0d gnt", v), 32'(ifa.gnt), 32'(vecs[v].gnt));
      chk($sformatf("v%0d err", v), 32'(ifa.err), 32'(vecs[v].err));
    end

    // Second connection on o1 next to input 1 on o0, then async reset mid-packet.
    ifa.req = 6'b001010;
    ifa.rel = 2'b00;
    tick();
    chk("two conn cfg", 32'(ifa.cfg), 32'h06);
    chk("two conn gnt", 32'(ifa.gnt), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst cfg", 32'(ifa.cfg), 32'h0);
    chk("async rst gnt", 32'(ifa.gnt), 32'h0);
    chk("async rst err", 32'(ifa.err), 32'h0);
    #2;
    rst_n = 1'b1;
    // o1 pointer was 1 before reset; a cleared pointer picks input 0.
    ifa.req = 6'b010010;
    tick();
    chk("post rst cfg", 32'(ifa.cfg), 32'h04);
    chk("post rst gnt", 32'(ifa.gnt), 32'h1);
    chk("post rst err", 32'(ifa.err), 32'h0);
    ifa.req = '0;
    ifa.rel = 2'b01;
    tick();
    ifa.rel = '0;
    chk("post rst rel", 32'(ifa.cfg), 32'h0);

    // Round robin across four inputs on a single output.
    ifb.req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      logic [3:0] exp;
      exp = 4'b0001 << (g % 4);
      chk($sformatf("rr%0d grant", g), 32'(ifb.gnt), 32'(exp));
      chk($sformatf("rr%0d cfg", g), 32'(ifb.cfg), 32'(exp));
      tick();
      chk($sformatf("rr%0d hold", g), 32'(ifb.gnt), 32'(exp));
      ifb.rel = exp;
      tick();
      ifb.rel = '0;
      chk($sformatf("rr%0d idle", g), 32'(ifb.gnt), 32'h0);
      if (g < 4) begin
        tick();
      end
    end
    chk("rr err", 32'(ifb.err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
